// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin 4-phase green/yellow/all-red sequencer with preempt; clock/clear in, req/preempt/preempt_phase in, lights/cur_phase/in_green/phase_start out
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_phase,
  output logic [7:0] lights,
  output logic [1:0] cur_phase,
  output logic       in_green,
  output logic       phase_start
);
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_t;
  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] cur_q, cur_d;
  logic [3:0] pending, cur_oh;
  logic [1:0] rr, pick;
  logic       other, ar_ready, grant, g_exit, g_sat, y_done;
  always_comb begin
    pending  = pend_q | req;
    cur_oh   = 4'b1 << cur_q;
    other    = |(pending & ~cur_oh);
    rr       = cur_q;
    for (int i = 4; i >= 1; i--)
      if (pending[2'(cur_q + 2'(i))]) rr = 2'(cur_q + 2'(i));
    pick     = preempt ? preempt_phase : rr;
    ar_ready = timer_q >= 8'(ALL_RED - 1);
    grant    = ar_ready && (preempt || |pending);
    g_sat    = timer_q == 8'(MAX_GREEN - 1);
    g_exit   = preempt ? preempt_phase != cur_q
                       : other && (g_sat || (timer_q >= 8'(MIN_GREEN - 1) && !req[cur_q]));
    y_done   = timer_q == 8'(YELLOW - 1);
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 8'd1;
    pend_d  = pending;
    cur_d   = cur_q;
    case (state_q)
      S_ALLRED: begin
        if (grant) begin
          state_d = S_GREEN;
          timer_d = '0;
          cur_d   = pick;
          pend_d  = pending & ~(4'b1 << pick);
        end else if (ar_ready) begin
          timer_d = timer_q;
        end
      end
      S_GREEN: begin
        pend_d = pending & ~cur_oh;
        if (g_exit) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end else if (g_sat) begin
          timer_d = timer_q;
        end
      end
      S_YELLOW: begin
        if (y_done) begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_ALLRED;
        timer_d = '0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_ALLRED;
      timer_q <= '0;
      pend_q  <= '0;
      cur_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
    end
  end
  assign in_green    = state_q == S_GREEN;
  assign phase_start = in_green && timer_q == 8'd0;
  assign cur_phase   = cur_q;
  assign lights      = in_green ? 8'b10 << {cur_q, 1'b0}
                     : state_q == S_YELLOW ? 8'b01 << {cur_q, 1'b0} : 8'h00;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: vector table, directed timing sequences and random run against an interval-level model
module tb_traffic_phase_scheduler;
  localparam int MIN_G = 8, MAX_G = 20, YEL = 4, AR = 2;
  logic       clock = 0, clear = 1, preempt = 0;
  logic [3:0] req = 0;
  logic [1:0] preempt_phase = 0;
  logic [7:0] lights;
  logic [1:0] cur_phase;
  logic       in_green, phase_start;
  int n_cmp = 0, n_bad = 0;
  int m_ph = 3, m_lit = 0, m_age = 0;
  logic [3:0] m_pend = 0;
  typedef struct {
    logic       clr;
    logic [3:0] rq;
    logic       pre;
    logic [1:0] pp;
    logic [7:0] lt;
    logic       ig;
    logic       ps;
    logic [1:0] cur;
  } vec_t;
  vec_t vec [13];
  always #5 clock = ~clock;
  traffic_phase_scheduler #(.MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL), .ALL_RED(AR)) dut (
    .clock(clock), .clear(clear), .req(req), .preempt(preempt), .preempt_phase(preempt_phase),
    .lights(lights), .cur_phase(cur_phase), .in_green(in_green), .phase_start(phase_start)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Model: m_lit is the light code shown by the served phase, m_age the unbounded cycles in that interval
  task automatic model_step();
    logic [3:0] pn;
    int pick;
    bit other, ex;
    pn = m_pend | req;
    if (clear) begin
      m_ph = 3; m_lit = 0; m_age = 0; m_pend = 0;
    end else if (m_lit == 0) begin
      if (m_age >= AR - 1 && (preempt || pn != 0)) begin
        pick = -1;
        if (preempt) pick = int'(preempt_phase);
        else for (int k = 1; k <= 4; k++) if (pick < 0 && pn[(m_ph + k) % 4]) pick = (m_ph + k) % 4;
        m_ph = pick; m_pend = pn & ~(4'b1 << pick); m_lit = 2; m_age = 0;
      end else begin
        m_age++; m_pend = pn;
      end
    end else if (m_lit == 2) begin
      other = (pn & ~(4'b1 << m_ph)) != 0;
      ex = preempt ? (int'(preempt_phase) != m_ph)
                   : other && (m_age >= MAX_G - 1 || (m_age >= MIN_G - 1 && !req[m_ph]));
      m_pend = pn & ~(4'b1 << m_ph);
      if (ex) begin m_lit = 1; m_age = 0; end else m_age++;
    end else begin
      m_pend = pn;
      if (m_age >= YEL - 1) begin m_lit = 0; m_age = 0; end else m_age++;
    end
  endtask
  task automatic step();
    logic [7:0] el;
    model_step();
    @(posedge clock);
    @(negedge clock);
    el = 8'(m_lit) << (2 * m_ph);
    chk("model_lights", lights, el);
    chk("model_in_green", in_green, m_lit == 2);
    chk("model_phase_start", phase_start, m_lit == 2 && m_age == 0);
    chk("model_cur_phase", cur_phase, m_ph);
  endtask
  task automatic do_reset();
    clear = 1; req = 0; preempt = 0; preempt_phase = 0;
    step();
    clear = 0;
  endtask
  task automatic wait_green(input int lim);
    int n;
    n = 0;
    while (!in_green && n < lim) begin step(); n++; end
    chk("wait_green", in_green, 1);
  endtask
  task automatic measure(input logic [7:0] code, output int n);
    n = 0;
    while (lights === code && n < 200) begin step(); n++; end
  endtask
  initial begin
    int g, n;
    logic [7:0] gc;
    vec[0]  = '{1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd3};
    vec[1]  = '{1'b0, 4'h1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd3};
    vec[2]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b1, 2'd0};
    vec[3]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b0, 2'd0};
    vec[4]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b0, 2'd0};
    vec[5]  = '{1'b0, 4'h0, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0, 2'd0};
    vec[6]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h01, 1'b0, 1'b0, 2'd0};
    vec[7]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h01, 1'b0, 1'b0, 2'd0};
    vec[8]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h01, 1'b0, 1'b0, 2'd0};
    vec[9]  = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0};
    vec[10] = '{1'b0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0};
    vec[11] = '{1'b0, 4'h8, 1'b0, 2'd0, 8'h80, 1'b1, 1'b1, 2'd3};
    vec[12] = '{1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd3};
    do_reset();
    for (int i = 0; i < 50; i++) step();
    chk("idle_lights", lights, 8'h00);
    chk("idle_in_green", in_green, 0);
    for (int i = 0; i < 13; i++) begin
      clear = vec[i].clr; req = vec[i].rq; preempt = vec[i].pre; preempt_phase = vec[i].pp;
      step();
      chk($sformatf("vec%0d_lights", i), lights, vec[i].lt);
      chk($sformatf("vec%0d_in_green", i), in_green, vec[i].ig);
      chk($sformatf("vec%0d_phase_start", i), phase_start, vec[i].ps);
      chk($sformatf("vec%0d_cur_phase", i), cur_phase, vec[i].cur);
    end
    clear = 0; req = 0; preempt = 0;
    do_reset();
    req = 1; step(); req = 0;
    wait_green(10);
    chk("first_green_lights", lights, 8'h02);
    for (int i = 0; i < 100; i++) step();
    chk("rest_green", lights, 8'h02);
    do_reset();
    req = 1;
    wait_green(10);
    g = 0;
    while (in_green && g < 100) begin req = (g == 3) ? 4'h5 : 4'h1; step(); g++; end
    chk("maxout_green_len", g, 20);
    measure(8'h01, n); chk("maxout_yellow_len", n, 4);
    measure(8'h00, n); chk("maxout_allred_len", n, 2);
    chk("maxout_next_lights", lights, 8'h20);
    req = 0; n = 0;
    while (lights !== 8'h10 && n < 50) begin step(); n++; end
    chk("reach_yellow2", lights, 8'h10);
    step();
    clear = 1; step(); clear = 0;
    chk("clear_mid_yellow_lights", lights, 8'h00);
    chk("clear_mid_yellow_cur", cur_phase, 3);
    for (int i = 0; i < 20; i++) step();
    chk("clear_drops_pend", lights, 8'h00);
    do_reset();
    req = 4'h2;
    wait_green(10);
    chk("gap_phase", cur_phase, 1);
    g = 0;
    while (in_green && g < 100) begin req = (g < 2) ? 4'b1010 : 4'b1000; step(); g++; end
    chk("gapout_green_len", g, 8);
    chk("gapout_yellow_code", lights, 8'h04);
    measure(8'h04, n); chk("gapout_yellow_len", n, 4);
    measure(8'h00, n); chk("gapout_allred_len", n, 2);
    chk("gapout_next_lights", lights, 8'h80);
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_green(20);
      chk($sformatf("rr%0d_phase", k), cur_phase, k % 4);
      gc = 8'b10 << (2 * (k % 4));
      measure(gc, g);
      chk($sformatf("rr%0d_green_len", k), g, 20);
      if (k < 4) begin
        n = 0;
        while (!in_green && n < 50) begin step(); n++; end
        chk($sformatf("rr%0d_gap", k), n, 6);
      end
    end
    do_reset();
    req = 4'h2;
    wait_green(10);
    step(); step();
    preempt = 1; preempt_phase = 3; req = 4'hF;
    step();
    chk("preempt_yellow_now", lights, 8'h04);
    measure(8'h04, n); chk("preempt_yellow_len", n, 4);
    measure(8'h00, n); chk("preempt_allred_len", n, 2);
    chk("preempt_green3", lights, 8'h80);
    for (int i = 0; i < 50; i++) step();
    chk("preempt_hold_green", in_green, 1);
    chk("preempt_hold_phase", cur_phase, 3);
    preempt = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin preempt = ~preempt; preempt_phase = 2'($urandom_range(0, 3)); end
      clear = $urandom_range(0, 499) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Four-phase intersection scheduler that decides which approach receives green, and for how long, from vehicle-detector requests and an emergency preempt. It sits above the per-approach light drivers: it owns phase sequencing (green -> yellow -> all-red -> next green) and drives a packed 2-bit light code per phase using the team's encoding red=0, yellow=1, green=2. Phase selection is round-robin, with min/max green timing, gap-out and preempt override.

## Interface
- MIN_GREEN, 8: minimum green cycles once another phase is waiting (1..255, <= MAX_GREEN)
- MAX_GREEN, 20: maximum green cycles when another phase is waiting (1..255)
- YELLOW, 4: yellow cycles (1..255)
- ALL_RED, 2: all-red clearance cycles (1..255)
- clock  in  1  single clock, all logic on posedge
- clear  in  1  synchronous, active-high reset
- req  in  4  per-phase vehicle detector, level, bit k = phase k
- preempt  in  1  emergency preempt, level
- preempt_phase  in  2  phase to serve while preempt=1
- lights  out  8  phase k light code at bits [2k+1:2k]
- cur_phase  out  2  phase currently or most recently served
- in_green  out  1  1 while FSM in GREEN
- phase_start  out  1  one-cycle pulse on the first green cycle of each phase

## Operation
- FSM states: ALLRED, GREEN, YELLOW. An 8-bit timer counts cycles spent in the current state and is zeroed on every state change.
- Request latch `pend[3:0]`: each cycle `pend |= req`, except bit cur_phase while in GREEN, which is not set. The granted phase's bit is cleared on the grant edge. Effective pending = `pend | req`.
- ALLRED: hold until timer reaches ALL_RED-1. From that cycle onward, pick the next phase:
  - preempt=1 -> preempt_phase, even if nothing is pending;
  - else round-robin search over pending, starting at cur_phase+1 (mod 4) and ending at cur_phase itself;
  - if nothing is pending and preempt=0 -> stay in ALLRED, timer saturated, lights all red.
  - On a successful pick -> GREEN next edge; cur_phase updates and phase_start pulses.
- GREEN (phase p), with `other = |(pending & ~onehot(p))`. Exit to YELLOW on the edge ending the cycle where either:
  - preempt=1 and preempt_phase != p, regardless of timer;
  - preempt=0, other=1 and timer == MAX_GREEN-1;
  - preempt=0, other=1, timer >= MIN_GREEN-1 and req[p]=0 (gap-out).
- Green hold cases:
  - preempt=1 with preempt_phase == p holds green indefinitely.
  - other=0 rests in green.
  - In both cases the timer saturates at MAX_GREEN-1.
- YELLOW: phase p shows yellow for exactly YELLOW cycles, then ALLRED. Preempt does not shorten YELLOW or ALLRED.
- lights is decoded combinationally from the registered state and cur_phase. Non-active phases are always red; at most one phase is non-red.
- cur_phase is meaningful only when in_green=1, or after the first grant.

## Timing
- Reset values (cycle after clear=1 sampled): FSM ALLRED, timer 0, pend 0, cur_phase 3, lights 8'h00, in_green 0, phase_start 0. With cur_phase 3, phase 0 has first round-robin priority.
- clear in any state, mid-yellow included, takes effect on the next edge. It overrides all other inputs.
- Fastest first green: clear deasserted with a request present gives ALL_RED all-red cycles, then green on the next edge.
- Green duration:
  - MIN_GREEN cycles on gap-out;
  - MAX_GREEN cycles with own request held;
  - if a competing request arrives after the timer has saturated, exit occurs on the next edge (max-out) or on the next edge after req[p] drops (gap-out).
- Phase-to-phase gap is always exactly YELLOW + ALL_RED cycles when a next phase is pending.
- Requests arriving in the same cycle as the ALLRED decision are included (req ORed into pending).

## Test plan
- Reset, req=0: lights=8'h00, in_green=0, stays all red for 50 cycles. Assert clear mid-YELLOW -> lights=8'h00, cur_phase=3, pend=0 next cycle.
- After reset, req=4'b0001 pulsed 1 cycle -> two all-red cycles, then lights=8'h02 with phase_start pulse. Rests green for 100 cycles with no other requests.
- Phase 0 green, req[0] held high, req[2] pulsed at green cycle 3 -> green 20 cycles, lights=8'h01 for 4 cycles, 8'h00 for 2 cycles, then 8'h20.
- Gap-out: phase 1 green, req[1] drops at cycle 2, req[3] held -> green exactly 8 cycles, then yellow (8'h04), all-red, then 8'h80.
- req=4'hF constant after reset -> served order 0,1,2,3,0. Each green lasts 20 cycles, with a 6-cycle gap between greens.
- Phase 1 green at cycle 2, preempt=1, preempt_phase=3 -> yellow on the next edge (skips MIN_GREEN), 4 yellow, 2 all-red, then 8'h80. Phase 3 is held green while preempt=1, even with req=4'hF.
